// File: rtl/key_pkg.sv
// Shared keypad constants: row/column key map, active-low hex glyphs and
// the hex digit / display-select types used by key_history.
package key_pkg;

  typedef logic [3:0] hex_t;

  typedef enum logic {
    SEL_CURR = 1'b0,
    SEL_PREV = 1'b1
  } sel_t;

  // Indexed [row][col]; row0 is the top row, col0 the left column.
  localparam hex_t KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // {g,f,e,d,c,b,a}, active-low, indexed by hex value.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_decode.sv
// Purely combinational hex to active-low seven-segment decoder.
module seg7_decode
  import key_pkg::*;
(
  input  hex_t       hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH[hex];
  end

endmodule

// File: rtl/key_history.sv
// Decodes keypad strobes into a two-key history and time-multiplexes both
// digits onto a shared active-low seven-segment bus.
module key_history
  import key_pkg::*;
#(
  parameter int unsigned MUX_DIV = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       newNum,
  input  logic [3:0] rows,
  input  logic [3:0] cols,
  output hex_t       curr,
  output hex_t       prev,
  output logic       dropped,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned CW = $clog2(MUX_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUX_DIV - 1);

  function automatic logic one_hot(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (v[b]) idx = 2'(b);
    end
    return idx;
  endfunction

  logic          valid;
  logic [CW-1:0] cnt;
  sel_t          sel;
  hex_t          digit;

  assign valid = one_hot(rows) && one_hot(cols);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curr    <= '0;
      prev    <= '0;
      dropped <= 1'b0;
    end else begin
      dropped <= newNum && !valid;
      if (newNum && valid) begin
        prev <= curr;
        curr <= KEY_MAP[enc(rows)][enc(cols)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      sel <= SEL_CURR;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      sel <= (sel == SEL_CURR) ? SEL_PREV : SEL_CURR;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    digit = curr;
    an    = 2'b10;
    if (sel == SEL_PREV) begin
      digit = prev;
      an    = 2'b01;
    end
  end

  seg7_decode u_dec (
    .hex (digit),
    .seg (seg)
  );

endmodule

// File: tb/tb_key_history.sv
// Bench for key_history: directed strobes on two instances (MUX_DIV 4 and 1)
// checked every cycle against a keypad/history model plus literal spot checks.
module tb_key_history;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       newNum = 1'b0;
  logic [3:0] rows = '0;
  logic [3:0] cols = '0;

  logic [3:0] curr4, prev4, curr1, prev1;
  logic       drop4, drop1;
  logic [6:0] seg4, seg1;
  logic [1:0] an4, an1;

  key_history #(.MUX_DIV(4)) dut (
    .clk(clk), .reset(reset), .newNum(newNum), .rows(rows), .cols(cols),
    .curr(curr4), .prev(prev4), .dropped(drop4), .seg(seg4), .an(an4)
  );

  key_history #(.MUX_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .newNum(newNum), .rows(rows), .cols(cols),
    .curr(curr1), .prev(prev1), .dropped(drop1), .seg(seg1), .an(an1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: key map as text, history as two registers, display
  // phase derived from edges elapsed since reset.
  string      keys = "123A456B789CE0FD";
  logic [6:0] gl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  int         k = 0;
  logic [3:0] m_curr = '0;
  logic [3:0] m_prev = '0;
  logic       m_drop = 1'b0;

  function automatic int bitpos(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] keyval(input string km, input logic [3:0] r, input logic [3:0] c);
    byte ch;
    ch = km[bitpos(r) * 4 + bitpos(c)];
    if (ch >= "A") return 4'(ch - "A" + 10);
    return 4'(ch - "0");
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k      <= 0;
      m_curr <= '0;
      m_prev <= '0;
      m_drop <= 1'b0;
    end else begin
      k      <= k + 1;
      m_drop <= newNum && !($countones(rows) == 1 && $countones(cols) == 1);
      if (newNum && $countones(rows) == 1 && $countones(cols) == 1) begin
        m_prev <= m_curr;
        m_curr <= keyval(keys, rows, cols);
      end
    end
  end

  function automatic logic shows_prev(input int kk, input int div);
    return ((kk / div) % 2) == 1;
  endfunction

  always @(negedge clk) begin
    chk("curr4", curr4, m_curr);
    chk("prev4", prev4, m_prev);
    chk("drop4", drop4, m_drop);
    chk("an4",   an4,   shows_prev(k, 4) ? 2'b01 : 2'b10);
    chk("seg4",  seg4,  shows_prev(k, 4) ? gl[m_prev] : gl[m_curr]);
    chk("curr1", curr1, m_curr);
    chk("prev1", prev1, m_prev);
    chk("drop1", drop1, m_drop);
    chk("an1",   an1,   shows_prev(k, 1) ? 2'b01 : 2'b10);
    chk("seg1",  seg1,  shows_prev(k, 1) ? gl[m_prev] : gl[m_curr]);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [3:0] r, input logic [3:0] c);
    newNum = 1'b1;
    rows   = r;
    cols   = c;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    #1 reset = 1'b0;
    repeat (3) step();
    chk("rst_curr", curr4, 4'h0);
    chk("rst_prev", prev4, 4'h0);
    chk("rst_drop", drop4, 1'b0);
    chk("rst_an",   an4,   2'b10);
    chk("rst_seg",  seg4,  7'b1000000);
    reset = 1'b1;

    // Idle for 3*MUX_DIV edges: digit select flips every 4 edges.
    for (int e = 1; e <= 12; e++) begin
      step();
      chk("idle_seg", seg4, 7'b1000000);
      case (e)
        3:  chk("idle_an3",  an4, 2'b10);
        4:  chk("idle_an4",  an4, 2'b01);
        8:  chk("idle_an8",  an4, 2'b10);
        12: chk("idle_an12", an4, 2'b01);
        default: ;
      endcase
    end

    strobe(4'b0001, 4'b0010);
    step();                                   // edge 13
    chk("key2_curr", curr4, 4'h2);
    strobe(4'b1000, 4'b0010);
    step();                                   // edge 14
    newNum = 1'b0;
    chk("key0_curr", curr4, 4'h0);
    chk("key0_prev", prev4, 4'h2);
    chk("key0_an",   an4,   2'b01);
    chk("key0_seg",  seg4,  7'b0100100);

    strobe(4'b0001, 4'b0011);
    step();                                   // edge 15
    chk("drop_multi", drop4, 1'b1);
    strobe(4'b0001, 4'b0000);
    step();                                   // edge 16
    newNum = 1'b0;
    chk("drop_zero", drop4, 1'b1);
    chk("drop_curr", curr4, 4'h0);
    chk("drop_prev", prev4, 4'h2);
    step();                                   // edge 17
    chk("drop_end", drop4, 1'b0);

    strobe(4'b0100, 4'b1000);
    step();                                   // edge 18
    strobe(4'b0010, 4'b1000);
    step();                                   // edge 19
    newNum = 1'b0;
    chk("b2b_curr", curr4, 4'hB);
    chk("b2b_prev", prev4, 4'hC);
    chk("b2b_drop", drop4, 1'b0);

    step();                                   // edge 20
    strobe(4'b1000, 4'b0001);
    step();                                   // edge 21: strobe and wrap together
    newNum = 1'b0;
    chk("wrap_an",   an1,  2'b01);
    chk("wrap_seg",  seg1, 7'b0000011);
    step();                                   // edge 22
    chk("wrap_an2",  an1,  2'b10);
    chk("wrap_seg2", seg1, 7'b0000110);

    strobe(4'b0100, 4'b0001);
    step();                                   // edge 23
    strobe(4'b0100, 4'b0100);
    step();                                   // edge 24
    newNum = 1'b0;
    chk("pre_curr", curr4, 4'h9);
    chk("pre_prev", prev4, 4'h7);

    #1 reset = 1'b0;
    #1;
    chk("async_curr", curr4, 4'h0);
    chk("async_prev", prev4, 4'h0);
    chk("async_an",   an4,   2'b10);
    chk("async_seg",  seg4,  7'b1000000);
    strobe(4'b0001, 4'b0001);
    step();
    chk("lost_curr", curr4, 4'h0);
    reset = 1'b1;
    step();
    newNum = 1'b0;
    chk("post_curr", curr4, 4'h1);
    chk("post_prev", prev4, 4'h0);
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_history.md
# key_history

Downstream consumer of the matrix keypad scanner. On each one-cycle `newNum` strobe it samples the active row and column lines and decodes them to a hexadecimal key value. It shifts that value into a two-digit history of most-recent and previous keys. It then time-multiplexes both digits onto a shared, active-low seven-segment bus for the dual-digit display.

## Interface
- `MUX_DIV`, default 20000: cycles each digit is shown before the digit select toggles; legal range ≥ 1.
- `clk` input, 1 bit: system clock, all state on rising edge.
- `reset` input, 1 bit: asynchronous, active-low; clears all state immediately.
- `newNum` input, 1 bit: one-cycle strobe from the scanner; a key press was detected this cycle.
- `rows` input, 4 bits: scanner's one-hot row drive; bit0 is the top row. Valid when `newNum` = 1.
- `cols` input, 4 bits: already-synchronized column sense, active-high; bit0 is the left column.
- `curr` output, 4 bits: most recent accepted key value. Reset 0.
- `prev` output, 4 bits: key accepted before `curr`. Reset 0.
- `dropped` output, 1 bit: one-cycle pulse when a strobe was rejected. Reset 0.
- `seg` output, 7 bits: {g,f,e,d,c,b,a}, active-low segment pattern of the selected digit. Reset pattern for 0 = 7'b1000000.
- `an` output, 2 bits: active-low digit enables; `an[0]` is the right digit (`curr`), `an[1]` is the left digit (`prev`). Reset 2'b10.

## Operation
- Keypad map by row/column:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- Accept rule: `newNum` = 1, `rows` is exactly one-hot, and `cols` is exactly one-hot.
  - On the next edge: `prev` ← `curr`, `curr` ← decoded value.
- Reject rule: `newNum` = 1 and either `rows` or `cols` is not one-hot (zero or multiple bits).
  - `curr`/`prev` are unchanged; `dropped` = 1 for exactly the next cycle.
- When `newNum` = 0, `rows`/`cols` are ignored and the history holds.
- Repeated identical keys are accepted normally, e.g. `curr` = `prev` = 5.
- Display mux uses a counter `cnt` of width $clog2(MUX_DIV+1) and a select bit `sel`.
  - `cnt` counts 0..MUX_DIV−1.
  - When `cnt` = MUX_DIV−1, `cnt` wraps to 0 and `sel` toggles.
  - `sel` = 0 drives `an` = 2'b10 and shows `curr`; `sel` = 1 drives `an` = 2'b01 and shows `prev`.
  - With MUX_DIV = 1, `sel` toggles every cycle.
- `seg`/`an` are combinational from the registered `sel`, `curr` and `prev`. No extra output register.
- Hex glyphs (active-low): 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.

## Timing
- Latency: a strobe in cycle N updates `curr`/`prev` (or pulses `dropped`) at the edge ending cycle N. New values are visible in cycle N+1.
- Back-to-back strobes in consecutive cycles are each processed; two accepts shift twice.
- A strobe coinciding with a mux wrap: both take effect at the same edge. `seg` in N+1 shows the new value of whichever digit the new `sel` selects.
- Reset asserted mid-operation: within the same cycle, all registers return to reset values and `an` = 2'b10, `seg` = 1000000. A strobe during reset is lost.
- Reset release: counting resumes from `cnt` = 0 at the first edge after deassertion.

## Structure
- Shared package `key_pkg` holds:
  - the 4×4 keypad map as a constant array indexed [row][col];
  - the 16-entry active-low glyph constant array;
  - a `logic [3:0]` hex typedef.
- One sub-module `seg7_decode` (4-bit in, 7-bit active-low out, purely combinational), instantiated once after the digit mux.
- One-hot checks and index encoding are local functions in `key_history`.

## Test plan
- Reset, then hold idle 3·MUX_DIV cycles (MUX_DIV = 4) → `curr` = `prev` = 0, `an` alternates 10/01 every 4 cycles, `seg` = 1000000 throughout.
- Strobe row0/col1, then row3/col1 → after the first edge `curr` = 2; after the second `curr` = 0, `prev` = 2; `seg` = 0100100 while `an` = 01.
- Strobe with `cols` = 4'b0011, then with `cols` = 0 → `dropped` pulses one cycle each; `curr`/`prev` unchanged.
- Strobes row2/col3 (C) and row1/col3 (B) in consecutive cycles → `curr` = B, `prev` = C; no `dropped`.
- Strobe row3/col0 on the same edge as a mux wrap with MUX_DIV = 1 → next cycle `an` = 01 and `seg` shows the old `curr`; the following cycle `an` = 10 and `seg` = 0000110 (E).
- Assert `reset` asynchronously mid-cycle with `curr` = 9, `prev` = 7 → outputs clear before the next clock edge; first post-reset strobe row0/col0 gives `curr` = 1, `prev` = 0.
